// File: rtl/psx_poller.sv
// Host-side PlayStation controller poll sequencer: shifts 01 42 00 00 00 out, collects the reply,
// checks the signature and publishes id/buttons. Optional auto-poll timer under PSX_AUTO_POLL_EN.
module psx_poller #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned ATT_SETUP   = 8,
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter int unsigned ATT_HOLD    = 8,
    parameter int unsigned POLL_PERIOD = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        data_i,
    input  logic        ack_i,
    output logic        psx_clk_o,
    output logic        att_o,
    output logic        cmd_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [7:0]  id_o,
    output logic [15:0] buttons_n_o
);

    localparam int unsigned Max1   = (CLK_DIV > ATT_SETUP) ? CLK_DIV : ATT_SETUP;
    localparam int unsigned Max2   = (ACK_TIMEOUT > ATT_HOLD) ? ACK_TIMEOUT : ATT_HOLD;
    localparam int unsigned CntMax = (Max1 > Max2) ? Max1 : Max2;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [2:0] {StIdle, StSetup, StShift, StAckWait, StHold} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [2:0]        byte_q, byte_d;
    logic              phase_q, phase_d;
    logic              ack_low_q, ack_low_d;
    logic              fail_q, fail_d;
    logic [7:0]        rx_q, rx_d;
    logic [7:0]        byte1_q, byte1_d;
    logic [7:0]        byte3_q, byte3_d;
    logic [7:0]        byte4_q, byte4_d;
    logic              att_q, att_d;
    logic              psx_clk_q, psx_clk_d;
    logic              cmd_q, cmd_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [7:0]        id_q, id_d;
    logic [15:0]       buttons_q, buttons_d;

    logic data_meta_q, data_sync_q, ack_meta_q, ack_sync_q;
    logic start_eff;
    logic [7:0] cur_cmd, next_cmd, rx_next;

    function automatic logic [7:0] cmd_byte(input logic [2:0] idx);
        unique case (idx)
            3'd0:    return 8'h01;
            3'd1:    return 8'h42;
            default: return 8'h00;
        endcase
    endfunction

`ifdef PSX_AUTO_POLL_EN
    localparam int unsigned PollW = $clog2(POLL_PERIOD + 1);
    logic [PollW-1:0] poll_cnt_q;
    logic             poll_tick;

    assign poll_tick = (poll_cnt_q == PollW'(POLL_PERIOD - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            poll_cnt_q <= '0;
        end else begin
            poll_cnt_q <= poll_tick ? '0 : poll_cnt_q + PollW'(1);
        end
    end

    assign start_eff = start_i | (poll_tick & ~busy_o);
`else
    assign start_eff = start_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            ack_meta_q  <= 1'b1;
            ack_sync_q  <= 1'b1;
        end else begin
            data_meta_q <= data_i;
            data_sync_q <= data_meta_q;
            ack_meta_q  <= ack_i;
            ack_sync_q  <= ack_meta_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        phase_d   = phase_q;
        ack_low_d = ack_low_q;
        fail_d    = fail_q;
        rx_d      = rx_q;
        byte1_d   = byte1_q;
        byte3_d   = byte3_q;
        byte4_d   = byte4_q;
        att_d     = att_q;
        psx_clk_d = psx_clk_q;
        cmd_d     = cmd_q;
        done_d    = 1'b0;
        error_d   = error_q;
        id_d      = id_q;
        buttons_d = buttons_q;
        cur_cmd   = cmd_byte(byte_q);
        next_cmd  = cmd_byte(byte_q + 3'd1);
        rx_next   = {data_sync_q, rx_q[7:1]};

        unique case (state_q)
            StIdle: begin
                if (start_eff) begin
                    state_d = StSetup;
                    att_d   = 1'b0;
                    byte_d  = 3'd0;
                    cnt_d   = '0;
                    fail_d  = 1'b0;
                end
            end
            StSetup: begin
                if (cnt_q == CntW'(ATT_SETUP - 1)) begin
                    state_d   = StShift;
                    cnt_d     = '0;
                    bit_d     = 3'd0;
                    phase_d   = 1'b0;
                    psx_clk_d = 1'b0;
                    cmd_d     = cur_cmd[0];
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StShift: begin
                if (cnt_q == CntW'(CLK_DIV - 1)) begin
                    cnt_d = '0;
                    if (!phase_q) begin
                        phase_d   = 1'b1;
                        psx_clk_d = 1'b1;
                    end else begin
                        rx_d    = rx_next;
                        phase_d = 1'b0;
                        if (bit_q != 3'd7) begin
                            bit_d     = bit_q + 3'd1;
                            psx_clk_d = 1'b0;
                            cmd_d     = cur_cmd[bit_q + 3'd1];
                        end else begin
                            // Byte 0 is don't-care; 1 and 2 carry the signature.
                            unique case (byte_q)
                                3'd1: begin
                                    byte1_d = rx_next;
                                    if (rx_next[7:4] != 4'h4) fail_d = 1'b1;
                                end
                                3'd2:    if (rx_next != 8'h5A) fail_d = 1'b1;
                                3'd3:    byte3_d = rx_next;
                                3'd4:    byte4_d = rx_next;
                                default: ;
                            endcase
                            cmd_d = 1'b1;
                            if (byte_q == 3'd4) begin
                                state_d = StHold;
                                att_d   = 1'b1;
                            end else begin
                                state_d   = StAckWait;
                                ack_low_d = 1'b0;
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StAckWait: begin
                if (ack_low_q && ack_sync_q) begin
                    byte_d    = byte_q + 3'd1;
                    state_d   = StShift;
                    cnt_d     = '0;
                    bit_d     = 3'd0;
                    phase_d   = 1'b0;
                    psx_clk_d = 1'b0;
                    cmd_d     = next_cmd[0];
                end else if (cnt_q == CntW'(ACK_TIMEOUT - 1)) begin
                    state_d   = StHold;
                    att_d     = 1'b1;
                    psx_clk_d = 1'b1;
                    cmd_d     = 1'b1;
                    fail_d    = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                    if (!ack_sync_q) ack_low_d = 1'b1;
                end
            end
            StHold: begin
                if (cnt_q == CntW'(ATT_HOLD - 1)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    error_d = fail_q;
                    if (!fail_q) begin
                        id_d      = byte1_q;
                        buttons_d = {byte4_q, byte3_q};
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_q     <= 3'd0;
            byte_q    <= 3'd0;
            phase_q   <= 1'b0;
            ack_low_q <= 1'b0;
            fail_q    <= 1'b0;
            rx_q      <= 8'h00;
            byte1_q   <= 8'h00;
            byte3_q   <= 8'h00;
            byte4_q   <= 8'h00;
            att_q     <= 1'b1;
            psx_clk_q <= 1'b1;
            cmd_q     <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            id_q      <= 8'h00;
            buttons_q <= 16'hFFFF;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            phase_q   <= phase_d;
            ack_low_q <= ack_low_d;
            fail_q    <= fail_d;
            rx_q      <= rx_d;
            byte1_q   <= byte1_d;
            byte3_q   <= byte3_d;
            byte4_q   <= byte4_d;
            att_q     <= att_d;
            psx_clk_q <= psx_clk_d;
            cmd_q     <= cmd_d;
            done_q    <= done_d;
            error_q   <= error_d;
            id_q      <= id_d;
            buttons_q <= buttons_d;
        end
    end

    assign psx_clk_o   = psx_clk_q;
    assign att_o       = att_q;
    assign cmd_o       = cmd_q;
    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q;
    assign error_o     = error_q;
    assign id_o        = id_q;
    assign buttons_n_o = buttons_q;

endmodule

// File: tb/tb_psx_poller.sv
// Bench for psx_poller: a cycle-sampled controller model answers each poll, and a reference
// model derived from the reply bytes predicts error/id/buttons and link timing.
module tb_psx_poller;

    localparam int unsigned CLK_DIV     = 4;
    localparam int unsigned ATT_SETUP   = 8;
    localparam int unsigned ACK_TIMEOUT = 64;
    localparam int unsigned ATT_HOLD    = 8;
    localparam logic [7:0] CMD_SEQ [5] = '{8'h01, 8'h42, 8'h00, 8'h00, 8'h00};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic data = 1'b1;
    logic ack = 1'b1;
    logic psx_clk_o, att_o, cmd_o, busy_o, done_o, error_o;
    logic [7:0]  id_o;
    logic [15:0] buttons_n_o;

    psx_poller #(
        .CLK_DIV    (CLK_DIV),
        .ATT_SETUP  (ATT_SETUP),
        .ACK_TIMEOUT(ACK_TIMEOUT),
        .ATT_HOLD   (ATT_HOLD),
        .POLL_PERIOD(1024)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .data_i     (data),
        .ack_i      (ack),
        .psx_clk_o  (psx_clk_o),
        .att_o      (att_o),
        .cmd_o      (cmd_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .error_o    (error_o),
        .id_o       (id_o),
        .buttons_n_o(buttons_n_o)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Controller model state and link observations.
    logic [7:0] reply [5];
    bit         ack_en [4];
    logic [7:0] cmd_seen [5];
    logic [2:0] dev_bit = 3'd0;
    logic [2:0] bytes_seen = 3'd0;
    int t_att_fall, t_att_rise, t_first_fall;
    int t_last_rise [5];
    int ack_dly = 0, ack_w = 0;
    int done_cnt = 0, att_falls = 0;
    logic prev_att = 1'b1, prev_psx = 1'b1;

    // Reference model of the published outputs.
    logic [7:0]  m_id = 8'h00;
    logic [15:0] m_btn = 16'hFFFF;
    logic        m_err = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_att = 1'b1; prev_psx = 1'b1; ack = 1'b1; data = 1'b1;
            ack_dly = 0; ack_w = 0; dev_bit = 3'd0; bytes_seen = 3'd0;
        end else begin
            if (done_o) done_cnt++;
            if (prev_att && !att_o) begin
                t_att_fall = cyc; att_falls++; dev_bit = 3'd0; bytes_seen = 3'd0;
            end
            if (!prev_att && att_o) t_att_rise = cyc;
            if (!att_o && bytes_seen < 3'd5) begin
                if (prev_psx && !psx_clk_o) begin
                    if (dev_bit == 3'd0 && bytes_seen == 3'd0) t_first_fall = cyc;
                    data = reply[bytes_seen][dev_bit];
                end
                if (!prev_psx && psx_clk_o) begin
                    cmd_seen[bytes_seen][dev_bit] = cmd_o;
                    if (dev_bit == 3'd7) begin
                        t_last_rise[bytes_seen] = cyc;
                        if (bytes_seen < 3'd4 && ack_en[bytes_seen[1:0]])
                            ack_dly = $urandom_range(20, 6);
                        dev_bit = 3'd0;
                        bytes_seen = bytes_seen + 3'd1;
                    end else begin
                        dev_bit = dev_bit + 3'd1;
                    end
                end
            end
            if (ack_dly > 0) begin
                ack_dly--;
                if (ack_dly == 0) begin ack = 1'b0; ack_w = $urandom_range(6, 3); end
            end else if (ack_w > 0) begin
                ack_w--;
                if (ack_w == 0) ack = 1'b1;
            end
            prev_att = att_o;
            prev_psx = psx_clk_o;
        end
    end

    task automatic set_reply(input logic [7:0] b0, b1, b2, b3, b4);
        reply[0] = b0; reply[1] = b1; reply[2] = b2; reply[3] = b3; reply[4] = b4;
        for (int i = 0; i < 4; i++) ack_en[i] = 1'b1;
    endtask

    // A poll fails on a missing ack or a bad signature; only good polls publish.
    task automatic model_poll();
        bit acks_ok = ack_en[0] && ack_en[1] && ack_en[2] && ack_en[3];
        bit fail = !acks_ok || (reply[1][7:4] != 4'h4) || (reply[2] != 8'h5A);
        m_err = fail;
        if (!fail) begin
            m_id  = reply[1];
            m_btn = {reply[4], reply[3]};
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done_o) begin timed_out = 1'b0; break; end
        end
    endtask

    task automatic wait_att(input logic lvl, input int limit, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < limit; i++) begin
            if (att_o === lvl) begin timed_out = 1'b0; break; end
            @(negedge clk);
        end
    endtask

    task automatic run_poll(output bit timed_out);
        for (int i = 0; i < 5; i++) cmd_seen[i] = 8'hEE;
        pulse_start();
        wait_done(3000, timed_out);
        repeat (2) @(negedge clk);
        model_poll();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({att_o, psx_clk_o, cmd_o} !== 3'b111) begin tests_failed++;
            $display("FAIL reset_lines: got %b want 111", {att_o, psx_clk_o, cmd_o}); end
        tests_run++;
        if ({busy_o, done_o, error_o} !== 3'b000) begin tests_failed++;
            $display("FAIL reset_status: got %b want 000", {busy_o, done_o, error_o}); end
        tests_run++;
        if (id_o !== 8'h00) begin tests_failed++;
            $display("FAIL reset_id: got %h want 00", id_o); end
        tests_run++;
        if (buttons_n_o !== 16'hFFFF) begin tests_failed++;
            $display("FAIL reset_buttons: got %h want ffff", buttons_n_o); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_good_poll();
        bit to;
        int d0 = done_cnt;
        set_reply(8'hFF, 8'h41, 8'h5A, 8'h7F, 8'hFF);
        run_poll(to);
        tests_run++;
        if (to) begin tests_failed++; $display("FAIL good_timeout: got timeout want done"); end
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (cmd_seen[i] !== CMD_SEQ[i]) begin tests_failed++;
                $display("FAIL good_cmd%0d: got %h want %h", i, cmd_seen[i], CMD_SEQ[i]); end
        end
        tests_run++;
        if (done_cnt - d0 != 1) begin tests_failed++;
            $display("FAIL good_done_count: got %0d want 1", done_cnt - d0); end
        tests_run++;
        if (error_o !== 1'b0) begin tests_failed++;
            $display("FAIL good_error: got %b want 0", error_o); end
        tests_run++;
        if (id_o !== 8'h41) begin tests_failed++;
            $display("FAIL good_id: got %h want 41", id_o); end
        tests_run++;
        if (buttons_n_o !== 16'hFF7F) begin tests_failed++;
            $display("FAIL good_buttons: got %h want ff7f", buttons_n_o); end
        tests_run++;
        if (t_first_fall - t_att_fall != int'(ATT_SETUP)) begin tests_failed++;
            $display("FAIL good_setup: got %0d want %0d", t_first_fall - t_att_fall, ATT_SETUP); end
        tests_run++;
        if (t_last_rise[0] - t_first_fall != int'(15 * CLK_DIV)) begin tests_failed++;
            $display("FAIL good_byte_len: got %0d want %0d", t_last_rise[0] - t_first_fall,
                     15 * CLK_DIV); end
        tests_run++;
        if (t_att_rise - t_last_rise[4] != int'(CLK_DIV)) begin tests_failed++;
            $display("FAIL good_last_half: got %0d want %0d", t_att_rise - t_last_rise[4],
                     CLK_DIV); end
    endtask

    task automatic test_random_polls();
        bit to;
        for (int n = 0; n < 8; n++) begin
            int d0 = done_cnt;
            logic [7:0] b1 = ($urandom_range(3, 0) != 0) ? {4'h4, 4'($urandom)} : 8'($urandom);
            logic [7:0] b2 = ($urandom_range(3, 0) != 0) ? 8'h5A : 8'($urandom);
            set_reply(8'($urandom), b1, b2, 8'($urandom), 8'($urandom));
            run_poll(to);
            tests_run++;
            if (to || done_cnt - d0 != 1) begin tests_failed++;
                $display("FAIL rand%0d_done: got timeout=%b count=%0d want 0 1", n, to,
                         done_cnt - d0); end
            tests_run++;
            if (error_o !== m_err) begin tests_failed++;
                $display("FAIL rand%0d_error: got %b want %b", n, error_o, m_err); end
            tests_run++;
            if (id_o !== m_id) begin tests_failed++;
                $display("FAIL rand%0d_id: got %h want %h", n, id_o, m_id); end
            tests_run++;
            if (buttons_n_o !== m_btn) begin tests_failed++;
                $display("FAIL rand%0d_buttons: got %h want %h", n, buttons_n_o, m_btn); end
        end
    endtask

    task automatic test_ack_timeout();
        bit to;
        int d0 = done_cnt;
        set_reply(8'hFF, 8'h73, 8'h5A, 8'h00, 8'h11);
        ack_en[2] = 1'b0;
        run_poll(to);
        tests_run++;
        if (to || done_cnt - d0 != 1) begin tests_failed++;
            $display("FAIL tmo_done: got timeout=%b count=%0d want 0 1", to, done_cnt - d0); end
        tests_run++;
        if (t_att_rise - t_last_rise[2] != int'(CLK_DIV + ACK_TIMEOUT)) begin tests_failed++;
            $display("FAIL tmo_att_rise: got %0d want %0d", t_att_rise - t_last_rise[2],
                     CLK_DIV + ACK_TIMEOUT); end
        tests_run++;
        if (bytes_seen !== 3'd3) begin tests_failed++;
            $display("FAIL tmo_bytes: got %0d want 3", bytes_seen); end
        tests_run++;
        if (error_o !== 1'b1 || m_err !== 1'b1) begin tests_failed++;
            $display("FAIL tmo_error: got %b want 1", error_o); end
        tests_run++;
        if ({id_o, buttons_n_o} !== {m_id, m_btn}) begin tests_failed++;
            $display("FAIL tmo_hold: got %h %h want %h %h", id_o, buttons_n_o, m_id, m_btn); end
    endtask

    task automatic test_bad_signature();
        bit to;
        set_reply(8'hFF, 8'h41, 8'h00, 8'hAB, 8'hCD);
        run_poll(to);
        tests_run++;
        if (to || error_o !== 1'b1) begin tests_failed++;
            $display("FAIL badsig_error: got timeout=%b error=%b want 0 1", to, error_o); end
        tests_run++;
        if ({id_o, buttons_n_o} !== {m_id, m_btn}) begin tests_failed++;
            $display("FAIL badsig_hold: got %h %h want %h %h", id_o, buttons_n_o, m_id, m_btn); end
        set_reply(8'h00, 8'h41, 8'h5A, 8'h34, 8'h12);
        run_poll(to);
        tests_run++;
        if (to || error_o !== 1'b0) begin tests_failed++;
            $display("FAIL badsig_recover: got timeout=%b error=%b want 0 0", to, error_o); end
        tests_run++;
        if (buttons_n_o !== 16'h1234 || id_o !== 8'h41) begin tests_failed++;
            $display("FAIL badsig_update: got %h %h want 41 1234", id_o, buttons_n_o); end
    endtask

    task automatic test_reset_mid();
        bit reached = 1'b0;
        int d0 = done_cnt;
        set_reply(8'hFF, 8'h41, 8'h5A, 8'h55, 8'hAA);
        pulse_start();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bytes_seen == 3'd3 && dev_bit >= 3'd3) begin reached = 1'b1; break; end
        end
        tests_run++;
        if (!reached) begin tests_failed++; $display("FAIL rstmid_reach: got timeout want byte3"); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({att_o, psx_clk_o, cmd_o} !== 3'b111) begin tests_failed++;
            $display("FAIL rstmid_lines: got %b want 111", {att_o, psx_clk_o, cmd_o}); end
        tests_run++;
        if (buttons_n_o !== 16'hFFFF || id_o !== 8'h00) begin tests_failed++;
            $display("FAIL rstmid_outputs: got %h %h want 00 ffff", id_o, buttons_n_o); end
        tests_run++;
        if ({busy_o, done_o, error_o} !== 3'b000) begin tests_failed++;
            $display("FAIL rstmid_status: got %b want 000", {busy_o, done_o, error_o}); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        m_id = 8'h00; m_btn = 16'hFFFF; m_err = 1'b0;
        tests_run++;
        if (done_cnt != d0) begin tests_failed++;
            $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cnt - d0); end
    endtask

    task automatic test_back_to_back();
        bit to;
        int r;
        int d0 = done_cnt;
        set_reply(8'hFF, 8'h41, 8'h5A, 8'h0F, 8'hF0);
        @(negedge clk); start = 1'b1;
        for (int g = 0; g < 3; g++) begin
            wait_att(1'b0, 3000, to);
            if (!to) wait_att(1'b1, 3000, to);
            r = cyc;
            if (!to) wait_att(1'b0, 3000, to);
            tests_run++;
            if (to || cyc - r != int'(ATT_HOLD + 1)) begin tests_failed++;
                $display("FAIL b2b_gap%0d: got timeout=%b gap=%0d want %0d", g, to, cyc - r,
                         ATT_HOLD + 1); end
            tests_run++;
            if (done_cnt - d0 != g + 1) begin tests_failed++;
                $display("FAIL b2b_done%0d: got %0d want %0d", g, done_cnt - d0, g + 1); end
        end
        start = 1'b0;
        wait_done(3000, to);
        repeat (2) @(negedge clk);
        model_poll();
        tests_run++;
        if (to || {error_o, buttons_n_o} !== {m_err, m_btn}) begin tests_failed++;
            $display("FAIL b2b_final: got %b %h want %b %h", error_o, buttons_n_o, m_err, m_btn); end
    endtask

    task automatic test_no_queue();
        bit to;
        int a0 = att_falls;
        int d0 = done_cnt;
        set_reply(8'hFF, 8'h41, 8'h5A, 8'h77, 8'h88);
        pulse_start();
        repeat (50) @(negedge clk);
        pulse_start();
        wait_done(3000, to);
        repeat (100) @(negedge clk);
        tests_run++;
        if (to || att_falls - a0 != 1) begin tests_failed++;
            $display("FAIL noqueue_att: got timeout=%b falls=%0d want 0 1", to, att_falls - a0); end
        tests_run++;
        if (done_cnt - d0 != 1 || busy_o !== 1'b0) begin tests_failed++;
            $display("FAIL noqueue_idle: got done=%0d busy=%b want 1 0", done_cnt - d0, busy_o); end
    endtask

    initial begin
        set_reply(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        test_reset();
        test_good_poll();
        test_random_polls();
        test_ack_timeout();
        test_bad_signature();
        test_reset_mid();
        test_back_to_back();
        test_no_queue();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
